// File: rtl/mem_responder.sv
// Dual-port (fetch/data) request/response memory with alternating arbitration
// and a fixed-latency response pipeline. Optional console sink at 15'h7FFF via MEM_CONSOLE_EN.
module mem_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [14:0] f_addr,
    output logic        f_rvalid,
    output logic [15:0] f_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic [14:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_rvalid,
    output logic [15:0] d_rdata
);

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    port_e       last_grant;
    logic        f_grant;
    logic        d_grant;
    logic [14:0] f_idx;
    logic [14:0] d_idx;
    logic [14:0] rd_idx;
    logic [15:0] rd_word;
    logic        console_hit;

    logic [15:0] mem [DEPTH];

    logic [LATENCY-1:0] pipe_vld;
    logic [LATENCY-1:0] pipe_we;
    port_e              pipe_port [LATENCY];
    logic [15:0]        pipe_data [LATENCY];

    // Readies depend only on the valids and last_grant; forced low in reset.
    always_comb begin
        f_ready = 1'b0;
        d_ready = 1'b0;
        if (rst_n) begin
            f_ready = f_valid && (!d_valid || (last_grant == PORT_DATA));
            d_ready = d_valid && (!f_valid || (last_grant == PORT_FETCH));
        end
    end

    assign f_grant = f_valid && f_ready;
    assign d_grant = d_valid && d_ready;

    always_comb begin
        f_idx  = 15'(32'(f_addr) % DEPTH);
        d_idx  = 15'(32'(d_addr) % DEPTH);
        rd_idx = f_grant ? f_idx : d_idx;
    end

    assign rd_word = mem[rd_idx];

`ifdef MEM_CONSOLE_EN
    assign console_hit = (d_addr == 15'h7FFF);

    always_ff @(posedge clk) begin
        if (d_grant && d_we && console_hit)
            $write("%c", d_wdata[7:0]);
    end
`else
    assign console_hit = 1'b0;
`endif

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (d_grant && d_we && !console_hit)
            mem[d_idx] <= d_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_DATA;
        end else if (f_grant) begin
            last_grant <= PORT_FETCH;
        end else if (d_grant) begin
            last_grant <= PORT_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_we  <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_port[i] <= PORT_FETCH;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= f_grant || d_grant;
            pipe_we[0]   <= d_grant && d_we;
            pipe_port[0] <= f_grant ? PORT_FETCH : PORT_DATA;
            pipe_data[0] <= rd_word;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_we[i]   <= pipe_we[i-1];
                pipe_port[i] <= pipe_port[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= pipe_vld[LATENCY-1] && (pipe_port[LATENCY-1] == PORT_FETCH);
            d_rvalid <= pipe_vld[LATENCY-1] && (pipe_port[LATENCY-1] == PORT_DATA);
            if (pipe_vld[LATENCY-1] && (pipe_port[LATENCY-1] == PORT_FETCH))
                f_rdata <= pipe_data[LATENCY-1];
            if (pipe_vld[LATENCY-1] && (pipe_port[LATENCY-1] == PORT_DATA))
                d_rdata <= pipe_we[LATENCY-1] ? '0 : pipe_data[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default LATENCY=2 instance plus a LATENCY=3 instance).
module tb_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        f_valid, f_ready, f_rvalid;
    logic [14:0] f_addr;
    logic [15:0] f_rdata;
    logic        d_valid, d_ready, d_we, d_rvalid;
    logic [14:0] d_addr;
    logic [15:0] d_wdata, d_rdata;

    logic        t3_f_valid, t3_f_ready, t3_f_rvalid;
    logic [14:0] t3_f_addr;
    logic [15:0] t3_f_rdata;
    logic        t3_d_valid, t3_d_ready, t3_d_we, t3_d_rvalid;
    logic [14:0] t3_d_addr;
    logic [15:0] t3_d_wdata, t3_d_rdata;

    int n_cmp;
    int n_err;

    mem_responder u_dut (
        .clk(clk), .rst_n(rst_n),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata)
    );

    mem_responder #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .f_valid(t3_f_valid), .f_ready(t3_f_ready), .f_addr(t3_f_addr),
        .f_rvalid(t3_f_rvalid), .f_rdata(t3_f_rdata),
        .d_valid(t3_d_valid), .d_ready(t3_d_ready), .d_we(t3_d_we), .d_addr(t3_d_addr),
        .d_wdata(t3_d_wdata), .d_rvalid(t3_d_rvalid), .d_rdata(t3_d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        f_valid = 1'b1;
        d_valid = 1'b1;
        d_we = 1'b1;
        d_addr = 15'd9;
        d_wdata = 16'hDEAD;
        step();
        step();
        n_cmp++; if (f_ready !== 1'b0) begin n_err++; $display("FAIL reset_f_ready: got %b want 0", f_ready); end
        n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL reset_d_ready: got %b want 0", d_ready); end
        n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_f_rvalid: got %b want 0", f_rvalid); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_d_rvalid: got %b want 0", d_rvalid); end
        n_cmp++; if (f_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_f_rdata: got %h want 0000", f_rdata); end
        n_cmp++; if (d_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_d_rdata: got %h want 0000", d_rdata); end
        f_valid = 1'b0;
        d_valid = 1'b0;
        d_we = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_then_fetch();
        d_valid = 1'b1; d_we = 1'b1; d_addr = 15'd5; d_wdata = 16'hBEEF;
        #1;
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL wf_d_ready: got %b want 1", d_ready); end
        n_cmp++; if (f_ready !== 1'b0) begin n_err++; $display("FAIL wf_f_ready_idle: got %b want 0", f_ready); end
        step();
        d_valid = 1'b0; d_we = 1'b0;
        f_valid = 1'b1; f_addr = 15'd5;
        #1;
        n_cmp++; if (f_ready !== 1'b1) begin n_err++; $display("FAIL wf_f_ready: got %b want 1", f_ready); end
        step();
        f_valid = 1'b0;
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL wf_d_rvalid_early: got %b want 0", d_rvalid); end
        step();
        n_cmp++; if (d_rvalid !== 1'b1) begin n_err++; $display("FAIL wf_d_rvalid: got %b want 1", d_rvalid); end
        n_cmp++; if (d_rdata !== 16'h0000) begin n_err++; $display("FAIL wf_d_rdata: got %h want 0000", d_rdata); end
        n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL wf_f_rvalid_early: got %b want 0", f_rvalid); end
        step();
        n_cmp++; if (f_rvalid !== 1'b1) begin n_err++; $display("FAIL wf_f_rvalid: got %b want 1", f_rvalid); end
        n_cmp++; if (f_rdata !== 16'hBEEF) begin n_err++; $display("FAIL wf_f_rdata: got %h want beef", f_rdata); end
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL wf_d_rvalid_pulse: got %b want 0", d_rvalid); end
        step();
        n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL wf_f_rvalid_pulse: got %b want 0", f_rvalid); end
        n_cmp++; if (f_rdata !== 16'hBEEF) begin n_err++; $display("FAIL wf_f_rdata_hold: got %h want beef", f_rdata); end
    endtask

    task automatic test_arbitration();
        logic exp_fr [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic exp_dr [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_fv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic exp_dv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        f_addr = 15'd5;
        d_addr = 15'd6; d_we = 1'b1; d_wdata = 16'h1234;
        for (int k = 0; k < 7; k++) begin
            f_valid = (k < 4);
            d_valid = (k < 4);
            #1;
            n_cmp++; if (f_ready !== exp_fr[k]) begin n_err++; $display("FAIL arb_f_ready[%0d]: got %b want %b", k, f_ready, exp_fr[k]); end
            n_cmp++; if (d_ready !== exp_dr[k]) begin n_err++; $display("FAIL arb_d_ready[%0d]: got %b want %b", k, d_ready, exp_dr[k]); end
            n_cmp++; if (f_rvalid !== exp_fv[k]) begin n_err++; $display("FAIL arb_f_rvalid[%0d]: got %b want %b", k, f_rvalid, exp_fv[k]); end
            n_cmp++; if (d_rvalid !== exp_dv[k]) begin n_err++; $display("FAIL arb_d_rvalid[%0d]: got %b want %b", k, d_rvalid, exp_dv[k]); end
            if (exp_fv[k]) begin
                n_cmp++; if (f_rdata !== 16'hBEEF) begin n_err++; $display("FAIL arb_f_rdata[%0d]: got %h want beef", k, f_rdata); end
            end
            if (exp_dv[k]) begin
                n_cmp++; if (d_rdata !== 16'h0000) begin n_err++; $display("FAIL arb_d_rdata[%0d]: got %h want 0000", k, d_rdata); end
            end
            step();
        end
        d_we = 1'b0;
    endtask

    task automatic test_reset_inflight();
        f_valid = 1'b1; f_addr = 15'd5;
        step();
        f_valid = 1'b0;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 15'd6;
        step();
        d_valid = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) rst_n = 1'b1;
            #1;
            n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_flight_f_rvalid[%0d]: got %b want 0", k, f_rvalid); end
            n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_flight_d_rvalid[%0d]: got %b want 0", k, d_rvalid); end
            step();
        end
        d_valid = 1'b1; d_we = 1'b0; d_addr = 15'd6;
        #1;
        n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL rst_after_d_ready: got %b want 1", d_ready); end
        step();
        d_valid = 1'b0;
        step();
        step();
        n_cmp++; if (d_rvalid !== 1'b1) begin n_err++; $display("FAIL rst_after_d_rvalid: got %b want 1", d_rvalid); end
        n_cmp++; if (d_rdata !== 16'h1234) begin n_err++; $display("FAIL rst_after_d_rdata: got %h want 1234", d_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [15:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            t3_d_valid = 1'b1; t3_d_we = 1'b1;
            t3_d_addr = 15'(i); t3_d_wdata = 16'(100 + i);
            step();
        end
        t3_d_valid = 1'b0; t3_d_we = 1'b0;
        for (int i = 0; i < 5; i++) step();
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                t3_d_valid = 1'b1; t3_d_addr = 15'(c);
                #1;
                n_cmp++; if (t3_d_ready !== 1'b1) begin n_err++; $display("FAIL b2b_d_ready[%0d]: got %b want 1", c, t3_d_ready); end
            end else begin
                t3_d_valid = 1'b0;
            end
            step();
            exp_v = (c >= 3) && (c <= 10);
            exp_d = (c >= 3) ? 16'(100 + c - 3) : 16'h0000;
            n_cmp++; if (t3_d_rvalid !== exp_v) begin n_err++; $display("FAIL b2b_d_rvalid[%0d]: got %b want %b", c, t3_d_rvalid, exp_v); end
            n_cmp++; if (t3_f_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_f_rvalid[%0d]: got %b want 0", c, t3_f_rvalid); end
            if (exp_v) begin
                n_cmp++; if (t3_d_rdata !== exp_d) begin n_err++; $display("FAIL b2b_d_rdata[%0d]: got %0d want %0d", c, t3_d_rdata, exp_d); end
            end
            if (c == 11) begin
                n_cmp++; if (t3_d_rdata !== 16'd107) begin n_err++; $display("FAIL b2b_d_rdata_hold: got %0d want 107", t3_d_rdata); end
            end
        end
    endtask

    task automatic test_console();
        logic [15:0] exp_rd;
`ifdef MEM_CONSOLE_EN
        d_valid = 1'b1; d_we = 1'b0; d_addr = 15'h7FFF;
        step();
        d_valid = 1'b0;
        step();
        step();
        exp_rd = d_rdata;
`else
        exp_rd = 16'h0041;
`endif
        d_valid = 1'b1; d_we = 1'b1; d_addr = 15'h7FFF; d_wdata = 16'h0041;
        step();
        d_valid = 1'b0; d_we = 1'b0;
        step();
        step();
        n_cmp++; if (d_rvalid !== 1'b1) begin n_err++; $display("FAIL con_wr_rvalid: got %b want 1", d_rvalid); end
        n_cmp++; if (d_rdata !== 16'h0000) begin n_err++; $display("FAIL con_wr_rdata: got %h want 0000", d_rdata); end
        d_valid = 1'b1; d_we = 1'b0; d_addr = 15'h7FFF;
        step();
        d_valid = 1'b0;
        step();
        step();
        n_cmp++; if (d_rvalid !== 1'b1) begin n_err++; $display("FAIL con_rd_rvalid: got %b want 1", d_rvalid); end
        n_cmp++; if (d_rdata !== exp_rd) begin n_err++; $display("FAIL con_rd_rdata: got %h want %h", d_rdata, exp_rd); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        f_valid = 1'b0; f_addr = '0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        t3_f_valid = 1'b0; t3_f_addr = '0;
        t3_d_valid = 1'b0; t3_d_we = 1'b0; t3_d_addr = '0; t3_d_wdata = '0;
        #1;
        test_reset();
        test_write_then_fetch();
        test_arbitration();
        test_reset_inflight();
        test_back_to_back();
        test_console();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
